// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter sharing one synchronous data memory between the core (port 0)
// and the comms network interface (port 1), with locked bursts. Optional counters: DATA_MEMORY_ARBITER_STATS_EN.
module data_memory_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_req,
    input  logic              core_we,
    input  logic              core_lock,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_gnt,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,
    input  logic              comms_req,
    input  logic              comms_we,
    input  logic              comms_lock,
    input  logic [ADDR_W-1:0] comms_addr,
    input  logic [DATA_W-1:0] comms_wdata,
    output logic              comms_gnt,
    output logic              comms_rvalid,
    output logic [DATA_W-1:0] comms_rdata,
    output logic [ADDR_W-1:0] mem_address_rw,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_write_enable,
    input  logic [DATA_W-1:0] mem_data_out
`ifdef DATA_MEMORY_ARBITER_STATS_EN
    ,
    output logic [15:0]       conflict_count,
    output logic [15:0]       core_grant_count,
    output logic [15:0]       comms_grant_count
`endif
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

    typedef enum logic [1:0] {
        IDLE,
        LOCK_CORE,
        LOCK_COMMS
    } state_e;

    typedef enum logic {
        PORT_CORE,
        PORT_COMMS
    } port_e;

    state_e           state, state_next;
    port_e            rr_ptr, rr_next;
    logic [CNT_W-1:0] burst_cnt, cnt_next, cnt_inc;
    logic             core_xfer, comms_xfer;

    assign core_xfer  = core_req && core_gnt;
    assign comms_xfer = comms_req && comms_gnt;
    assign cnt_inc    = burst_cnt + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rr_ptr       <= PORT_CORE;
            burst_cnt    <= '0;
            core_rvalid  <= 1'b0;
            comms_rvalid <= 1'b0;
        end else begin
            state        <= state_next;
            rr_ptr       <= rr_next;
            burst_cnt    <= cnt_next;
            core_rvalid  <= core_xfer && !core_we;
            comms_rvalid <= comms_xfer && !comms_we;
        end
    end

    always_comb begin
        state_next = state;
        rr_next    = rr_ptr;
        cnt_next   = burst_cnt;
        case (state)
            IDLE: begin
                if (core_xfer) begin
                    rr_next = PORT_COMMS;
                    if (core_lock) begin
                        state_next = LOCK_CORE;
                        cnt_next   = CNT_W'(1);
                    end
                end else if (comms_xfer) begin
                    rr_next = PORT_CORE;
                    if (comms_lock) begin
                        state_next = LOCK_COMMS;
                        cnt_next   = CNT_W'(1);
                    end
                end
            end
            LOCK_CORE: begin
                if (core_xfer) begin
                    cnt_next = cnt_inc;
                    // Release hands priority to the other port, also on forced release.
                    if (!core_lock || cnt_inc == MAX_CNT) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                        rr_next    = PORT_COMMS;
                    end
                end
            end
            LOCK_COMMS: begin
                if (comms_xfer) begin
                    cnt_next = cnt_inc;
                    if (!comms_lock || cnt_inc == MAX_CNT) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                        rr_next    = PORT_CORE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        core_gnt  = 1'b0;
        comms_gnt = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    core_gnt  = core_req && (!comms_req || rr_ptr == PORT_CORE);
                    comms_gnt = comms_req && (!core_req || rr_ptr == PORT_COMMS);
                end
                LOCK_CORE:  core_gnt  = core_req;
                LOCK_COMMS: comms_gnt = comms_req;
                default: begin
                    core_gnt  = 1'b0;
                    comms_gnt = 1'b0;
                end
            endcase
        end
        if (comms_gnt) begin
            mem_address_rw = comms_addr;
            mem_data_in    = comms_wdata;
        end else begin
            mem_address_rw = core_addr;
            mem_data_in    = core_wdata;
        end
        mem_write_enable = (core_gnt && core_we) || (comms_gnt && comms_we);
    end

    assign core_rdata  = mem_data_out;
    assign comms_rdata = mem_data_out;

`ifdef DATA_MEMORY_ARBITER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_count    <= '0;
            core_grant_count  <= '0;
            comms_grant_count <= '0;
        end else begin
            if (core_req && comms_req && (core_gnt != comms_gnt) && conflict_count != '1)
                conflict_count <= conflict_count + 16'd1;
            if (core_xfer && core_grant_count != '1)
                core_grant_count <= core_grant_count + 16'd1;
            if (comms_xfer && comms_grant_count != '1)
                comms_grant_count <= comms_grant_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed bench for data_memory_arbiter with a behavioural synchronous RAM;
// the counter test is built only with DATA_MEMORY_ARBITER_STATS_EN.
module tb_data_memory_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_req, core_we, core_lock;
    logic [15:0] core_addr, core_wdata;
    logic        core_gnt, core_rvalid;
    logic [15:0] core_rdata;
    logic        comms_req, comms_we, comms_lock;
    logic [15:0] comms_addr, comms_wdata;
    logic        comms_gnt, comms_rvalid;
    logic [15:0] comms_rdata;
    logic [15:0] mem_address_rw, mem_data_in, mem_data_out;
    logic        mem_write_enable;
`ifdef DATA_MEMORY_ARBITER_STATS_EN
    logic [15:0] conflict_count, core_grant_count, comms_grant_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] ram [0:255];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_write_enable) ram[mem_address_rw[7:0]] <= mem_data_in;
        mem_data_out <= ram[mem_address_rw[7:0]];
    end

    data_memory_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_BURST(8)) dut (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_we(core_we), .core_lock(core_lock),
        .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
        .comms_req(comms_req), .comms_we(comms_we), .comms_lock(comms_lock),
        .comms_addr(comms_addr), .comms_wdata(comms_wdata),
        .comms_gnt(comms_gnt), .comms_rvalid(comms_rvalid), .comms_rdata(comms_rdata),
        .mem_address_rw(mem_address_rw), .mem_data_in(mem_data_in),
        .mem_write_enable(mem_write_enable), .mem_data_out(mem_data_out)
`ifdef DATA_MEMORY_ARBITER_STATS_EN
        ,
        .conflict_count(conflict_count), .core_grant_count(core_grant_count),
        .comms_grant_count(comms_grant_count)
`endif
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        core_req = 0; core_we = 0; core_lock = 0; core_addr = 16'h0; core_wdata = 16'h0;
        comms_req = 0; comms_we = 0; comms_lock = 0; comms_addr = 16'h0; comms_wdata = 16'h0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst = 1;
        cyc();
        cyc();
        rst = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        core_req = 1; comms_req = 1; core_we = 1; comms_we = 1;
        cyc();
        cyc();
        #1;
        n_checks++;
        if (core_gnt !== 1'b0 || comms_gnt !== 1'b0) begin
            n_fail++; $display("FAIL reset_gnt: got core=%b comms=%b expected 0 0", core_gnt, comms_gnt);
        end
        n_checks++;
        if (mem_write_enable !== 1'b0) begin
            n_fail++; $display("FAIL reset_we: got %b expected 0", mem_write_enable);
        end
        n_checks++;
        if (core_rvalid !== 1'b0 || comms_rvalid !== 1'b0) begin
            n_fail++; $display("FAIL reset_rvalid: got core=%b comms=%b expected 0 0", core_rvalid, comms_rvalid);
        end
        rst = 0;
        idle_inputs();
    endtask

    task automatic test_single_read();
        core_req = 1; core_we = 1; core_addr = 16'h0010; core_wdata = 16'hBEEF;
        #1;
        n_checks++;
        if (core_gnt !== 1'b1 || mem_write_enable !== 1'b1 || mem_address_rw !== 16'h0010 || mem_data_in !== 16'hBEEF) begin
            n_fail++; $display("FAIL wr_drive: got gnt=%b we=%b addr=%h data=%h expected 1 1 0010 beef",
                               core_gnt, mem_write_enable, mem_address_rw, mem_data_in);
        end
        cyc();
        core_we = 0;
        #1;
        n_checks++;
        if (core_gnt !== 1'b1 || mem_write_enable !== 1'b0 || core_rvalid !== 1'b0) begin
            n_fail++; $display("FAIL rd_issue: got gnt=%b we=%b rvalid=%b expected 1 0 0",
                               core_gnt, mem_write_enable, core_rvalid);
        end
        cyc();
        core_req = 0; core_addr = 16'h0055;
        #1;
        n_checks++;
        if (core_rvalid !== 1'b1 || core_rdata !== 16'hBEEF || comms_rvalid !== 1'b0) begin
            n_fail++; $display("FAIL rd_return: got rvalid=%b rdata=%h comms_rvalid=%b expected 1 beef 0",
                               core_rvalid, core_rdata, comms_rvalid);
        end
        n_checks++;
        if (core_gnt !== 1'b0 || mem_address_rw !== 16'h0055) begin
            n_fail++; $display("FAIL idle_mux: got gnt=%b addr=%h expected 0 0055", core_gnt, mem_address_rw);
        end
        cyc();
        n_checks++;
        if (core_rvalid !== 1'b0) begin
            n_fail++; $display("FAIL rd_pulse: got rvalid=%b expected 0", core_rvalid);
        end
    endtask

    task automatic test_round_robin();
        int core_cnt = 0;
        int comms_cnt = 0;
        logic exp_core;
        apply_reset();
        core_req = 1; core_addr = 16'h0011;
        comms_req = 1; comms_addr = 16'h0010;
        for (int k = 0; k < 8; k++) begin
            #1;
            exp_core = (k % 2 == 0);
            n_checks++;
            if (core_gnt !== exp_core || comms_gnt !== !exp_core) begin
                n_fail++; $display("FAIL rr_gnt[%0d]: got core=%b comms=%b expected %b %b",
                                   k, core_gnt, comms_gnt, exp_core, !exp_core);
            end
            if (k > 0) begin
                n_checks++;
                if (core_rvalid !== !exp_core || comms_rvalid !== exp_core) begin
                    n_fail++; $display("FAIL rr_rvalid[%0d]: got core=%b comms=%b expected %b %b",
                                       k, core_rvalid, comms_rvalid, !exp_core, exp_core);
                end
                if (exp_core) begin
                    n_checks++;
                    if (comms_rdata !== 16'hBEEF) begin
                        n_fail++; $display("FAIL rr_rdata[%0d]: got %h expected beef", k, comms_rdata);
                    end
                end
            end
            if (core_gnt === 1'b1) core_cnt++;
            if (comms_gnt === 1'b1) comms_cnt++;
            cyc();
        end
        n_checks++;
        if (core_cnt != 4 || comms_cnt != 4) begin
            n_fail++; $display("FAIL rr_count: got core=%0d comms=%0d expected 4 4", core_cnt, comms_cnt);
        end
        idle_inputs();
    endtask

    task automatic test_lock_burst();
        apply_reset();
        comms_req = 1; comms_we = 1; comms_lock = 1; comms_addr = 16'h0020; comms_wdata = 16'hA020;
        #1;
        n_checks++;
        if (comms_gnt !== 1'b1 || core_gnt !== 1'b0 || mem_write_enable !== 1'b1 || mem_address_rw !== 16'h0020) begin
            n_fail++; $display("FAIL lock_b0: got comms=%b core=%b we=%b addr=%h expected 1 0 1 0020",
                               comms_gnt, core_gnt, mem_write_enable, mem_address_rw);
        end
        cyc();
        for (int b = 1; b < 4; b++) begin
            core_req = 1; core_we = 0; core_addr = 16'h0022;
            comms_addr = 16'h0020 + 16'(b);
            comms_wdata = 16'hA020 + 16'(b);
            comms_lock = (b < 3);
            #1;
            n_checks++;
            if (comms_gnt !== 1'b1 || core_gnt !== 1'b0 || mem_address_rw !== comms_addr || mem_data_in !== comms_wdata) begin
                n_fail++; $display("FAIL lock_b%0d: got comms=%b core=%b addr=%h data=%h expected 1 0 %h %h",
                                   b, comms_gnt, core_gnt, mem_address_rw, mem_data_in, comms_addr, comms_wdata);
            end
            cyc();
        end
        comms_req = 0; comms_lock = 0; comms_we = 0;
        #1;
        n_checks++;
        if (core_gnt !== 1'b1 || comms_gnt !== 1'b0) begin
            n_fail++; $display("FAIL lock_release: got core=%b comms=%b expected 1 0", core_gnt, comms_gnt);
        end
        cyc();
        core_req = 0;
        #1;
        n_checks++;
        if (core_rvalid !== 1'b1 || core_rdata !== 16'hA022) begin
            n_fail++; $display("FAIL lock_readback: got rvalid=%b rdata=%h expected 1 a022", core_rvalid, core_rdata);
        end
        idle_inputs();
    endtask

    task automatic test_forced_release();
        int xfers = 0;
        apply_reset();
        comms_req = 1; comms_lock = 1; comms_addr = 16'h0020;
        for (int k = 0; k < 8; k++) begin
            if (k == 1) begin
                core_req = 1; core_addr = 16'h0011;
            end
            #1;
            n_checks++;
            if (comms_gnt !== 1'b1 || core_gnt !== 1'b0) begin
                n_fail++; $display("FAIL burst_beat[%0d]: got comms=%b core=%b expected 1 0", k, comms_gnt, core_gnt);
            end
            if (comms_gnt === 1'b1) xfers++;
            cyc();
        end
        #1;
        n_checks++;
        if (core_gnt !== 1'b1 || comms_gnt !== 1'b0) begin
            n_fail++; $display("FAIL forced_release: got core=%b comms=%b expected 1 0", core_gnt, comms_gnt);
        end
        cyc();
        #1;
        n_checks++;
        if (comms_gnt !== 1'b1 || core_gnt !== 1'b0) begin
            n_fail++; $display("FAIL regrant_comms: got comms=%b core=%b expected 1 0", comms_gnt, core_gnt);
        end
        n_checks++;
        if (xfers != 8) begin
            n_fail++; $display("FAIL burst_len: got %0d expected 8", xfers);
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_burst();
        apply_reset();
        comms_req = 1; comms_lock = 1; comms_addr = 16'h0020;
        cyc();
        core_req = 1; core_addr = 16'h0011;
        #1;
        n_checks++;
        if (comms_gnt !== 1'b1 || core_gnt !== 1'b0) begin
            n_fail++; $display("FAIL mid_beat2: got comms=%b core=%b expected 1 0", comms_gnt, core_gnt);
        end
        cyc();
        rst = 1;
        #1;
        n_checks++;
        if (comms_gnt !== 1'b0 || core_gnt !== 1'b0 || mem_write_enable !== 1'b0) begin
            n_fail++; $display("FAIL mid_rst_gnt: got comms=%b core=%b we=%b expected 0 0 0",
                               comms_gnt, core_gnt, mem_write_enable);
        end
        cyc();
        rst = 0; comms_req = 0; comms_lock = 0;
        #1;
        n_checks++;
        if (core_gnt !== 1'b1 || comms_rvalid !== 1'b0) begin
            n_fail++; $display("FAIL post_rst: got core_gnt=%b comms_rvalid=%b expected 1 0", core_gnt, comms_rvalid);
        end
        cyc();
        idle_inputs();
    endtask

`ifdef DATA_MEMORY_ARBITER_STATS_EN
    task automatic test_stats();
        apply_reset();
        core_req = 1; comms_req = 1;
        for (int k = 0; k < 10; k++) cyc();
        idle_inputs();
        #1;
        n_checks++;
        if (conflict_count !== 16'd10 || core_grant_count !== 16'd5 || comms_grant_count !== 16'd5) begin
            n_fail++; $display("FAIL stats: got conflict=%0d core=%0d comms=%0d expected 10 5 5",
                               conflict_count, core_grant_count, comms_grant_count);
        end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_single_read();
        test_round_robin();
        test_lock_burst();
        test_forced_release();
        test_reset_mid_burst();
`ifdef DATA_MEMORY_ARBITER_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
